// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver: transmit FSM
// state encoding, frame geometry constants and the default bit period.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam int   UART_FRAME_BITS = 10;
    localparam logic UART_LINE_IDLE  = 1'b1;

    // 50 MHz / 115200 baud; the receiver uses the same value.
    localparam int   UART_CLKS_PER_BAUD_DEFAULT = 434;

endpackage : uart_pkg

// File: rtl/uart_baud_ctr.sv
// -----------------------------------------------------------------------------
// uart_baud_ctr
// Bit-period counter. Counts 0..CLKS_PER_BAUD_PERIOD-1 while enabled and
// wraps at each bit boundary; held at zero while disabled.
// Ports:
//   i_clk    - system clock
//   i_rst_n  - synchronous active-low reset
//   en       - count enable
//   count    - current position inside the bit period
//   bit_end  - high in the last cycle of a bit period (only when enabled)
// -----------------------------------------------------------------------------
module uart_baud_ctr
    import uart_pkg::*;
#(
    parameter int   CLKS_PER_BAUD_PERIOD = UART_CLKS_PER_BAUD_DEFAULT,
    localparam int  CNT_W = (CLKS_PER_BAUD_PERIOD > 1) ? $clog2(CLKS_PER_BAUD_PERIOD) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             bit_end
);

    if (CLKS_PER_BAUD_PERIOD < 2) begin : g_bad_period
        $error("uart_baud_ctr: CLKS_PER_BAUD_PERIOD must be >= 2");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BAUD_PERIOD - 1);

    logic [CNT_W-1:0] count_r;

    // Bit-period counter: wraps at the last count, parked at zero when idle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (!en) begin
            count_r <= {CNT_W{1'b0}};
        end else if (count_r == LAST_CNT) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign count   = count_r;
    assign bit_end = en && (count_r == LAST_CNT);

endmodule : uart_baud_ctr

// File: rtl/uart_txr.sv
// -----------------------------------------------------------------------------
// uart_txr
// 8N1 UART transmitter with a one-byte holding register so that a byte
// queued during a frame follows the current stop bit with no idle gap.
// Ports:
//   i_clk         - system clock (rising edge)
//   i_rst_n       - synchronous active-low reset
//   i_data_valid  - host presents a byte
//   i_data_byte   - byte to send, sampled only when accepted
//   o_data_ready  - a byte can be accepted this cycle (holding register empty)
//   o_tx_line     - registered serial output, idle high
//   o_busy        - a frame is being driven
//   o_tx_done     - one-cycle pulse in the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_txr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BAUD_PERIOD = UART_CLKS_PER_BAUD_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_data_valid,
    input  logic [7:0] i_data_byte,
    output logic       o_data_ready,
    output logic       o_tx_line,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam int CNT_W = (CLKS_PER_BAUD_PERIOD > 1) ? $clog2(CLKS_PER_BAUD_PERIOD) : 1;
    // Seeing this count in STOP means the next cycle is the final stop cycle,
    // which lets o_tx_done come straight from a flop.
    localparam logic [CNT_W-1:0] PRE_LAST_CNT = CNT_W'(CLKS_PER_BAUD_PERIOD - 2);
    localparam logic [2:0]       LAST_BIT     = 3'(UART_DATA_BITS - 1);

    tx_state_t                   state_r, state_s;
    logic [UART_DATA_BITS-1:0]   shift_r, shift_s;
    logic [UART_DATA_BITS-1:0]   hold_r, hold_s;
    logic                        hold_full_r, hold_full_s;
    logic [2:0]                  bit_ctr_r, bit_ctr_s;
    logic                        tx_line_r, tx_line_s;
    logic                        busy_r, ready_r, done_r, done_s;
    logic                        accept_s, baud_en_s, bit_end_s;
    logic [CNT_W-1:0]            baud_cnt_s;

    assign accept_s  = i_data_valid && ready_r;
    assign baud_en_s = (state_r != IDLE);

    uart_baud_ctr #(
        .CLKS_PER_BAUD_PERIOD(CLKS_PER_BAUD_PERIOD)
    ) u_baud_ctr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .en      (baud_en_s),
        .count   (baud_cnt_s),
        .bit_end (bit_end_s)
    );

    // Next-state logic for the frame FSM, shift register and holding register.
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        bit_ctr_s   = bit_ctr_r;

        // Any byte accepted mid-frame is parked in the holding register.
        if (accept_s && (state_r != IDLE)) begin
            hold_s      = i_data_byte;
            hold_full_s = 1'b1;
        end else begin
            hold_s      = hold_r;
        end

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    shift_s = i_data_byte;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    bit_ctr_s = 3'd0;
                end else begin
                    state_s   = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_s = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    if (bit_ctr_r == LAST_BIT) begin
                        state_s = STOP;
                    end else begin
                        bit_ctr_s = bit_ctr_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (hold_full_r) begin
                        shift_s     = hold_r;
                        hold_full_s = 1'b0;
                        state_s     = START;
                    end else if (accept_s) begin
                        // Byte arriving on the boundary goes straight to the shifter.
                        shift_s     = i_data_byte;
                        hold_s      = hold_r;
                        hold_full_s = 1'b0;
                        state_s     = START;
                    end else begin
                        state_s     = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level for the upcoming cycle, derived from the next state.
    always_comb begin
        tx_line_s = UART_LINE_IDLE;
        case (state_s)
            IDLE:    tx_line_s = UART_LINE_IDLE;
            START:   tx_line_s = 1'b0;
            DATA:    tx_line_s = shift_s[0];
            STOP:    tx_line_s = 1'b1;
            default: tx_line_s = UART_LINE_IDLE;
        endcase
    end

    assign done_s = (state_r == STOP) && (baud_cnt_s == PRE_LAST_CNT);

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r     <= IDLE;
            shift_r     <= {UART_DATA_BITS{1'b0}};
            hold_r      <= {UART_DATA_BITS{1'b0}};
            hold_full_r <= 1'b0;
            bit_ctr_r   <= 3'd0;
            tx_line_r   <= UART_LINE_IDLE;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_r     <= shift_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            bit_ctr_r   <= bit_ctr_s;
            tx_line_r   <= tx_line_s;
            busy_r      <= (state_s != IDLE);
            ready_r     <= !hold_full_s;
            done_r      <= done_s;
        end
    end

    assign o_data_ready = ready_r;
    assign o_tx_line    = tx_line_r;
    assign o_busy       = busy_r;
    assign o_tx_done    = done_r;

endmodule : uart_txr
